br_update_scheduler: RTL and testbench
======================================

# br_update_scheduler

Sequencer that owns the write side of the global (gshare-style) pattern history table (PHT) in the fetch-stage branch predictor. It keeps the architectural global history register (GHR), queues resolved conditional-branch outcomes from EX/MEM, and drains them into the PHT write port one per granted cycle. It also runs a full-table initialization sweep after reset or on a flush request. The predictor's lookup path stays combinational and reads `ghr` and `init_busy` from this block.

## Interface
- `IDX_BITS`, default 4: PHT index width; the table has 2^IDX_BITS entries.
- `QDEPTH`, default 4: update queue depth; must be a power of 2 and at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `stall`  in  1  pipeline stall; when high, EX/MEM is not sampled.
- `ex_mem_opcode`  in  rv32i_opcode  opcode of the instruction in EX/MEM.
- `ex_mem_pc`  in  32  PC of the instruction in EX/MEM.
- `ex_mem_br_en`  in  1  resolved direction (1 = taken).
- `flush_req`  in  1  single-cycle request to clear the predictor state.
- `wr_ready`  in  1  PHT write port is available this cycle.
- `ghr`  out  IDX_BITS  architectural global history, used by lookup for index XOR.
- `tbl_we`  out  1  PHT write strobe.
- `tbl_waddr`  out  IDX_BITS  PHT entry address.
- `tbl_winit`  out  1  write `strongly_not_taken` instead of updating the counter.
- `tbl_wtaken`  out  1  counter direction: 1 = saturating increment, 0 = saturating decrement.
- `init_busy`  out  1  sweep in progress; lookup must predict not-taken.
- `stall_req`  out  1  queue full; the hazard unit must stall.
- `overflow`  out  1  sticky flag: an update was dropped.

## Operation
- FSM states `INIT` and `RUN`; reset enters `INIT`.
- On reset: `ghr=0`, sweep counter=0, queue empty, `overflow=0`.
- `INIT` state:
  - `tbl_we=wr_ready`, `tbl_winit=1`, `tbl_waddr`=sweep counter.
  - The counter increments only on cycles where `wr_ready=1`.
  - After the write at address 2^IDX_BITS-1, go to `RUN` and reset the counter to 0.
  - EX/MEM branches seen during `INIT` are ignored: no enqueue, no GHR change, no overflow.
- `RUN` state, enqueue:
  - Condition: `!stall && ex_mem_opcode==op_br`.
  - Push {idx = `ghr ^ ex_mem_pc[IDX_BITS+1:2]`, taken = `ex_mem_br_en`}.
  - Same edge: `ghr <= {ghr[IDX_BITS-2:0], ex_mem_br_en}`.
  - The index uses the GHR value from before the shift.
  - The GHR updates even if the push is dropped.
- `RUN` state, drain:
  - When the queue is non-empty and `wr_ready=1`: `tbl_we=1`, `tbl_winit=0`, `tbl_waddr`=head idx, `tbl_wtaken`=head taken. Pop at the edge.
  - When the queue is empty, `tbl_we=0`.
- Queue boundaries:
  - Full with a simultaneous pop: the push is accepted.
  - Full with no pop: the push is dropped and `overflow` is set until reset.
  - Occupancy counter width is log2(QDEPTH)+1; pointers wrap modulo QDEPTH.
- `stall_req`: high exactly when occupancy == QDEPTH (combinational from registers).
- `flush_req` in `RUN`:
  - Next edge: queue emptied, `ghr=0`, state goes to `INIT`, counter=0.
  - An enqueue in the same cycle is discarded.
  - A drain write in the same cycle still happens (`tbl_we` is driven that cycle).
- `flush_req` in `INIT`: restarts the sweep from 0.
- `init_busy` = (state == `INIT`).
- Outputs are combinational from state only: no input-to-output paths except `wr_ready` to `tbl_we`.
- When `tbl_we=0`, `tbl_winit`, `tbl_wtaken` and `tbl_waddr` are don't-care; drive them to 0.

## Timing
- Reset values: `ghr=0`, `init_busy=1`, `tbl_we=0` (asserted asynchronously; after release it follows `wr_ready`), `tbl_winit=1`, `tbl_waddr=0`, `tbl_wtaken=0`, `stall_req=0`, `overflow=0`.
- Sweep length: 2^IDX_BITS granted cycles. `init_busy` falls on the edge after the last sweep write.
- Update latency: an enqueue at edge N can be written at the earliest in cycle N+1. There is no same-cycle bypass.
- Throughput: one drain per cycle and one enqueue per cycle.
- `rst_n` asserted mid-sweep or mid-drain: immediate asynchronous return to reset values; the sweep restarts after release.

## Structure
- Shared package `rv32i_types` holds:
  - `op_br` and the 2-bit counter constants (already present);
  - new enum `br_sched_state_t` {`INIT`, `RUN`};
  - new struct `br_upd_t` {idx, taken}.
- Sub-module `br_update_fifo`: parameterised depth and type. Ports: push, pop, data in/out, full, empty, count; asynchronous active-low reset. The scheduler instantiates it once.

## Test plan
- Reset release with IDX_BITS=4 and `wr_ready`=1: 16 consecutive writes with `tbl_winit=1` at addresses 0..15, then `init_busy=0` at cycle 17.
- `wr_ready` low every other cycle during the sweep: 16 writes spread over 32 cycles, addresses strictly sequential with none skipped.
- In `RUN`, branches at pc 0x1004 (taken) then 0x1008 (not taken) starting from `ghr=0`:
  - writes to idx 1 with `wtaken=1`, then idx 3 (`ghr`=1 ^ 2) with `wtaken=0`;
  - final `ghr=2`.
- `wr_ready`=0 and 5 back-to-back branches with QDEPTH=4: `stall_req` rises after the 4th push, the 5th push is dropped, `overflow=1`, and `ghr` has shifted 5 times.
- Queue full, then `wr_ready`=1 with a simultaneous push: both the pop and the push occur, occupancy stays 4, `overflow` unchanged.
- `flush_req` with 3 entries queued: queue empties, `ghr=0`, `init_busy=1` next cycle, full sweep repeats; asserting `rst_n` low mid-sweep restarts from address 0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types.
// Holds the opcode encoding, the PHT 2-bit counter values, and the
// branch-update scheduler state and queue record types.
package rv32i_types;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef enum logic [1:0] {
      strongly_not_taken = 2'b00,
      weakly_not_taken   = 2'b01,
      weakly_taken       = 2'b10,
      strongly_taken     = 2'b11
   } pht_ctr_t;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } br_sched_state_t;

   // Widest PHT index a queued update can carry; users narrow it to
   // their own index width.
   localparam int unsigned BR_IDX_MAX_W = 16;

   typedef struct packed {
      logic [BR_IDX_MAX_W-1:0] idx;
      logic                    taken;
   } br_upd_t;

endpackage

// File: rtl/br_update_fifo.sv
// Small synchronous FIFO for queued PHT updates.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clear             synchronous flush of all entries
//   push, din         write request and data (accepted when not full or
//                     when a pop happens in the same cycle)
//   pop, dout         read request and head entry (ignored when empty)
//   full, empty       occupancy flags
//   count             occupancy, 0..DEPTH
module br_update_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter type         T     = logic
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  T                         din,
   input  logic                     pop,
   output T                         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);

   T               mem_q [DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PW:0]    count_q, count_d;
   logic           do_push, do_pop;

   assign full  = (count_q == (PW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign dout  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty;
      // A full queue still accepts a push when the head leaves this cycle.
      do_push  = push && (!full || do_pop) && !clear;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/br_update_scheduler.sv
// Write-side sequencer for the gshare pattern history table.
// Keeps the global history register, queues resolved conditional-branch
// outcomes from EX/MEM and drains one per granted cycle into the PHT
// write port. Runs a full-table init sweep after reset or a flush.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   stall                              EX/MEM not sampled when high
//   ex_mem_opcode/pc/br_en             resolved instruction in EX/MEM
//   flush_req                          clear predictor state
//   wr_ready                           PHT write port grant
//   ghr                                global history for lookup XOR
//   tbl_we/waddr/winit/wtaken          PHT write port
//   init_busy                          sweep in progress
//   stall_req                          update queue full
//   overflow                           sticky: an update was dropped
module br_update_scheduler
   import rv32i_types::*;
#(
   parameter int unsigned IDX_BITS = 4,
   parameter int unsigned QDEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 stall,
   input  rv32i_opcode          ex_mem_opcode,
   input  logic [31:0]          ex_mem_pc,
   input  logic                 ex_mem_br_en,
   input  logic                 flush_req,
   input  logic                 wr_ready,
   output logic [IDX_BITS-1:0]  ghr,
   output logic                 tbl_we,
   output logic [IDX_BITS-1:0]  tbl_waddr,
   output logic                 tbl_winit,
   output logic                 tbl_wtaken,
   output logic                 init_busy,
   output logic                 stall_req,
   output logic                 overflow
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   br_sched_state_t        state_q, state_d;
   logic [IDX_BITS-1:0]    sweep_q, sweep_d;
   logic [IDX_BITS-1:0]    ghr_q, ghr_d;
   logic                   overflow_q, overflow_d;

   logic                   br_seen;
   logic                   fifo_push, fifo_pop, fifo_clear;
   logic                   fifo_full, fifo_empty;
   logic [CW-1:0]          fifo_count;
   br_upd_t                upd_in, upd_head;

   // Only the index bits of the PC feed the hash.
   logic                   unused_pc_bits;
   assign unused_pc_bits = ^{ex_mem_pc[31:IDX_BITS+2], ex_mem_pc[1:0]};

   br_update_fifo #(
      .DEPTH (QDEPTH),
      .T     (br_upd_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (fifo_clear),
      .push  (fifo_push),
      .din   (upd_in),
      .pop   (fifo_pop),
      .dout  (upd_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      state_d    = state_q;
      sweep_d    = sweep_q;
      ghr_d      = ghr_q;
      overflow_d = overflow_q;
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_clear = 1'b0;
      br_seen    = !stall && (ex_mem_opcode == op_br);
      // Hash uses the history before this branch shifts in.
      upd_in.idx   = BR_IDX_MAX_W'(ghr_q ^ ex_mem_pc[IDX_BITS+1:2]);
      upd_in.taken = ex_mem_br_en;

      case (state_q)
         INIT: begin
            if (flush_req) begin
               sweep_d = '0;
            end else if (wr_ready) begin
               // Wraps back to 0 on the last entry, ready for the next sweep.
               sweep_d = sweep_q + 1'b1;
               if (sweep_q == '1) state_d = RUN;
            end
         end
         RUN: begin
            // The drain write still lands in a flush cycle.
            fifo_pop = wr_ready && !fifo_empty;
            if (flush_req) begin
               fifo_clear = 1'b1;
               ghr_d      = '0;
               sweep_d    = '0;
               state_d    = INIT;
            end else if (br_seen) begin
               fifo_push = 1'b1;
               ghr_d     = {ghr_q[IDX_BITS-2:0], ex_mem_br_en};
               if (fifo_full && !fifo_pop) overflow_d = 1'b1;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         sweep_q    <= '0;
         ghr_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sweep_q    <= sweep_d;
         ghr_q      <= ghr_d;
         overflow_q <= overflow_d;
      end
   end

   // Write port: only wr_ready (and the async reset on the strobe) reach
   // the outputs combinationally.
   always_comb begin
      tbl_we     = 1'b0;
      tbl_waddr  = '0;
      tbl_winit  = 1'b0;
      tbl_wtaken = 1'b0;
      if (state_q == INIT) begin
         tbl_we    = wr_ready && rst_n;
         tbl_winit = 1'b1;
         tbl_waddr = tbl_we ? sweep_q : '0;
      end else if (wr_ready && !fifo_empty) begin
         tbl_we     = 1'b1;
         tbl_waddr  = IDX_BITS'(upd_head.idx);
         tbl_wtaken = upd_head.taken;
      end
   end

   assign ghr       = ghr_q;
   assign init_busy = (state_q == INIT);
   assign stall_req = (fifo_count == CW'(QDEPTH));
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_br_update_scheduler.sv
module tb_br_update_scheduler;
   import rv32i_types::*;

   localparam int IDX_BITS = 4;
   localparam int QDEPTH   = 4;
   localparam int NENT     = 1 << IDX_BITS;

   logic                clk;
   logic                rst_n;
   logic                stall;
   rv32i_opcode         ex_mem_opcode;
   logic [31:0]         ex_mem_pc;
   logic                ex_mem_br_en;
   logic                flush_req;
   logic                wr_ready;
   logic [IDX_BITS-1:0] ghr;
   logic                tbl_we;
   logic [IDX_BITS-1:0] tbl_waddr;
   logic                tbl_winit;
   logic                tbl_wtaken;
   logic                init_busy;
   logic                stall_req;
   logic                overflow;

   br_update_scheduler #(.IDX_BITS(IDX_BITS), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .ex_mem_opcode(ex_mem_opcode),
      .ex_mem_pc(ex_mem_pc), .ex_mem_br_en(ex_mem_br_en), .flush_req(flush_req),
      .wr_ready(wr_ready), .ghr(ghr), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr),
      .tbl_winit(tbl_winit), .tbl_wtaken(tbl_wtaken), .init_busy(init_busy),
      .stall_req(stall_req), .overflow(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int idx; bit taken; } upd_m_t;
   upd_m_t mq[$];
   bit     m_init;
   int     m_sweep;
   int     m_ghr;
   bit     m_ovf;

   task automatic model_reset();
      mq.delete();
      m_init  = 1'b1;
      m_sweep = 0;
      m_ghr   = 0;
      m_ovf   = 1'b0;
   endtask

   task automatic model_check(input string tag);
      bit e_we;
      e_we = m_init ? bit'(wr_ready) : (mq.size() != 0 && wr_ready);
      chk({tag, ".init_busy"}, int'(init_busy), int'(m_init));
      chk({tag, ".tbl_we"}, int'(tbl_we), int'(e_we));
      chk({tag, ".ghr"}, int'(ghr), m_ghr);
      chk({tag, ".stall_req"}, int'(stall_req), int'(mq.size() == QDEPTH));
      chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
      if (e_we) begin
         chk({tag, ".waddr"}, int'(tbl_waddr), m_init ? m_sweep : mq[0].idx);
         chk({tag, ".winit"}, int'(tbl_winit), int'(m_init));
         if (!m_init) chk({tag, ".wtaken"}, int'(tbl_wtaken), int'(mq[0].taken));
      end else if (!m_init) begin
         chk({tag, ".idle_port"}, int'({tbl_waddr, tbl_winit, tbl_wtaken}), 0);
      end
   endtask

   task automatic model_step();
      if (m_init) begin
         if (flush_req) m_sweep = 0;
         else if (wr_ready) begin
            m_sweep++;
            if (m_sweep == NENT) begin
               m_init  = 1'b0;
               m_sweep = 0;
            end
         end
      end else begin
         if (mq.size() != 0 && wr_ready) void'(mq.pop_front());
         if (flush_req) begin
            mq.delete();
            m_ghr   = 0;
            m_init  = 1'b1;
            m_sweep = 0;
         end else if (!stall && ex_mem_opcode == op_br) begin
            if (mq.size() < QDEPTH)
               mq.push_back('{idx: (m_ghr ^ int'(ex_mem_pc >> 2)) % NENT, taken: ex_mem_br_en});
            else
               m_ovf = 1'b1;
            m_ghr = (m_ghr * 2 + int'(ex_mem_br_en)) % NENT;
         end
      end
   endtask

   task automatic settle_check(input string tag);
      #1;
      model_check(tag);
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic set_in(input bit s, input bit br, input logic [31:0] pc,
                         input bit en, input bit fl, input bit wr);
      stall         = s;
      ex_mem_opcode = br ? op_br : op_reg;
      ex_mem_pc     = pc;
      ex_mem_br_en  = en;
      flush_req     = fl;
      wr_ready      = wr;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit stall; bit br; logic [31:0] pc; bit br_en; bit flush; bit wr;
      bit e_we; int e_addr; bit e_tk; int e_ghr; bit e_full; bit e_ovf;
   } vec_t;
   vec_t vecs[$];

   initial begin
      int exp_addr, writes, busy_cycles, r;

      // stall, br, pc, en, flush, wr | we, addr, tk, ghr, full, ovf
      vecs.push_back('{0, 1, 32'h1004, 1, 0, 0,  0, 0, 0,  0, 0, 0});
      vecs.push_back('{0, 1, 32'h1008, 0, 0, 1,  1, 1, 1,  1, 0, 0});
      vecs.push_back('{0, 0, 32'h0000, 0, 0, 1,  1, 3, 0,  2, 0, 0});
      vecs.push_back('{1, 1, 32'h1004, 1, 0, 0,  0, 0, 0,  2, 0, 0});
      vecs.push_back('{0, 1, 32'h2000, 1, 0, 0,  0, 0, 0,  2, 0, 0});
      vecs.push_back('{0, 1, 32'h2004, 0, 0, 0,  0, 0, 0,  5, 0, 0});
      vecs.push_back('{0, 1, 32'h2008, 1, 0, 0,  0, 0, 0, 10, 0, 0});
      vecs.push_back('{0, 1, 32'h200c, 1, 0, 0,  0, 0, 0,  5, 0, 0});
      vecs.push_back('{0, 1, 32'h2010, 0, 0, 0,  0, 0, 0, 11, 1, 0});
      vecs.push_back('{0, 0, 32'h0000, 0, 0, 0,  0, 0, 0,  6, 1, 1});
      vecs.push_back('{0, 1, 32'h2000, 1, 0, 1,  1, 2, 1,  6, 1, 1});
      vecs.push_back('{0, 0, 32'h0000, 0, 0, 0,  0, 0, 0, 13, 1, 1});
      vecs.push_back('{0, 0, 32'h0000, 0, 0, 1,  1, 4, 0, 13, 1, 1});
      vecs.push_back('{0, 1, 32'h2004, 1, 1, 1,  1, 8, 1, 13, 0, 1});

      // Reset values, held while wr_ready is high.
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, 0, 1);
      model_reset();
      @(negedge clk);
      #1;
      chk("rst.tbl_we", int'(tbl_we), 0);
      chk("rst.init_busy", int'(init_busy), 1);
      chk("rst.tbl_winit", int'(tbl_winit), 1);
      chk("rst.others", int'({ghr, tbl_waddr, tbl_wtaken, stall_req, overflow}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sweep with continuous grant: 16 writes then RUN in cycle 17.
      for (int i = 0; i < NENT; i++) begin
         settle_check("sweep1");
         chk("sweep1_addr", int'(tbl_waddr), i);
         chk("sweep1_we", int'(tbl_we), 1);
         advance();
      end
      #1;
      chk("sweep1_done", int'(init_busy), 0);

      foreach (vecs[i]) begin
         set_in(vecs[i].stall, vecs[i].br, vecs[i].pc, vecs[i].br_en, vecs[i].flush, vecs[i].wr);
         settle_check("vec");
         chk($sformatf("vec%0d.we", i), int'(tbl_we), int'(vecs[i].e_we));
         chk($sformatf("vec%0d.ghr", i), int'(ghr), vecs[i].e_ghr);
         chk($sformatf("vec%0d.stall_req", i), int'(stall_req), int'(vecs[i].e_full));
         chk($sformatf("vec%0d.overflow", i), int'(overflow), int'(vecs[i].e_ovf));
         chk($sformatf("vec%0d.busy", i), int'(init_busy), 0);
         if (vecs[i].e_we) begin
            chk($sformatf("vec%0d.waddr", i), int'(tbl_waddr), vecs[i].e_addr);
            chk($sformatf("vec%0d.wtaken", i), int'(tbl_wtaken), int'(vecs[i].e_tk));
            chk($sformatf("vec%0d.winit", i), int'(tbl_winit), 0);
         end
         advance();
      end

      // After the flush: sweep repeats with wr_ready on every other cycle.
      set_in(0, 1, 32'h3004, 1, 0, 0);
      #1;
      chk("flush.busy", int'(init_busy), 1);
      chk("flush.ghr", int'(ghr), 0);
      chk("flush.stall_req", int'(stall_req), 0);
      exp_addr = 0; writes = 0; busy_cycles = 0;
      for (int k = 0; k < 40; k++) begin
         wr_ready = k[0];
         settle_check("alt");
         if (!init_busy) break;
         busy_cycles++;
         if (tbl_we) begin
            chk("alt_addr", int'(tbl_waddr), exp_addr);
            exp_addr++;
            writes++;
         end
         advance();
      end
      chk("alt_writes", writes, NENT);
      chk("alt_cycles", busy_cycles, 2 * NENT);
      chk("alt_ghr_untouched", int'(ghr), 0);

      // Flush into a sweep, then reset asynchronously mid-sweep.
      set_in(0, 0, 0, 0, 1, 1);
      settle_check("flush2");
      advance();
      flush_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         settle_check("pre_rst");
         advance();
      end
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst.we", int'(tbl_we), 0);
      chk("async_rst.busy", int'(init_busy), 1);
      chk("async_rst.waddr", int'(tbl_waddr), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      settle_check("restart");
      chk("restart.addr", int'(tbl_waddr), 0);
      chk("restart.we", int'(tbl_we), 1);
      advance();
      for (int i = 0; i < 40 && m_init; i++) begin
         settle_check("restart_sweep");
         advance();
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         stall         = ($urandom_range(0, 3) == 0);
         ex_mem_opcode = (r < 55) ? op_br : ((r < 80) ? op_load : op_jal);
         ex_mem_pc     = $urandom;
         ex_mem_br_en  = $urandom_range(0, 1);
         flush_req     = ($urandom_range(0, 79) == 0);
         wr_ready      = ($urandom_range(0, 9) < 4);
         settle_check("rand");
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
